// File: rtl/pixel_pkg.sv
// Shared definitions for the interleaved-to-paired pixel demultiplexer:
// default widths, FSM state encoding and the output pair layout.
package pixel_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 12;

    typedef enum logic [1:0] {
        S_EVEN  = 2'd0,
        S_ODD   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    // Pair layout at the default pixel width; modules with a different
    // DATA_W declare the same fields locally at their own width.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] even;
        logic [DATA_W_DEF-1:0] odd;
        logic                  odd_vld;
        logic                  last;
    } pixel_pair_t;

    function automatic int pair_width(input int data_w);
        return 2 * data_w + 2;
    endfunction

endpackage

// File: rtl/pixel_pair_demux_pair_out_reg.sv
// Single-entry output register with valid/ready; a new entry may be loaded
// in the same cycle the current one drains, so a full stream has no bubble.
module pair_out_reg #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         free
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    assign free      = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            // Data fields keep their last value once drained.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pixel_pair_demux.sv
// Splits an interleaved pixel stream into even/odd lane pairs, one pair per
// output beat; lines with an odd pixel count are closed with a padded pair.
module pixel_pair_demux
    import pixel_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] PAD_VAL = '0,
    parameter int                CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_even,
    output logic [DATA_W-1:0] out_odd,
    output logic              out_odd_vld,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  pair_cnt,
    output logic              odd_line
);

    typedef struct packed {
        logic [DATA_W-1:0] even;
        logic [DATA_W-1:0] odd;
        logic              odd_vld;
        logic              last;
    } pair_t;

    localparam int PAIR_W = pair_width(DATA_W);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] hold_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              odd_line_q;
    logic              odd_line_d;

    logic              load;
    pair_t             load_pair;
    pair_t             out_pair;
    logic              out_free;
    logic              out_xfer;

    pair_out_reg #(
        .W (PAIR_W)
    ) u_pair_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_pair),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_pair),
        .free      (out_free)
    );

    // Pairing FSM: the even sample waits in hold_q until its partner arrives.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        odd_line_d = 1'b0;
        load       = 1'b0;
        load_pair  = '0;
        in_ready   = 1'b0;
        case (state_q)
            S_EVEN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_d  = in_data;
                    state_d = in_last ? S_FLUSH : S_ODD;
                end
            end
            S_ODD: begin
                in_ready = out_free;
                if (in_valid && out_free) begin
                    load              = 1'b1;
                    load_pair.even    = hold_q;
                    load_pair.odd     = in_data;
                    load_pair.odd_vld = 1'b1;
                    load_pair.last    = in_last;
                    state_d           = S_EVEN;
                end
            end
            S_FLUSH: begin
                if (out_free) begin
                    load              = 1'b1;
                    load_pair.even    = hold_q;
                    load_pair.odd     = PAD_VAL;
                    load_pair.odd_vld = 1'b0;
                    load_pair.last    = 1'b1;
                    odd_line_d        = 1'b1;
                    state_d           = S_EVEN;
                end
            end
            default: begin
                state_d = S_EVEN;
            end
        endcase
    end

    assign out_xfer = out_valid & out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (out_xfer) begin
            cnt_d = out_pair.last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EVEN;
            hold_q     <= '0;
            cnt_q      <= '0;
            odd_line_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            odd_line_q <= odd_line_d;
        end
    end

    assign out_even    = out_pair.even;
    assign out_odd     = out_pair.odd;
    assign out_odd_vld = out_pair.odd_vld;
    assign out_last    = out_pair.last;
    assign pair_cnt    = cnt_q;
    assign odd_line    = odd_line_q;

endmodule
